// File: rtl/spike_aer_sender.sv
// spike_aer_sender: turns fired-neuron events into AER packets
// read from the AER table (unicast entry or multicast chain).
module spike_aer_sender #(
  parameter int NURN_CNT_BIT_WIDTH = 8,
  parameter int AER_BIT_WIDTH      = 32,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          spike_valid_i,
  output logic                          spike_ready_o,
  input  logic [NURN_CNT_BIT_WIDTH-1:0] spike_nurn_id_i,
  input  logic [3:0]                    spike_aer_num_i,
  input  logic [NURN_CNT_BIT_WIDTH-1:0] spike_aer_ptr_i,
  input  logic                          multicast_i,
  output logic [NURN_CNT_BIT_WIDTH:0]   aer_addr_o,
  output logic                          aer_rd_en_o,
  input  logic [AER_BIT_WIDTH-1:0]      aer_data_i,
  output logic                          pkt_valid_o,
  output logic [AER_BIT_WIDTH-1:0]      pkt_data_o,
  input  logic                          pkt_ready_i,
  output logic [CNT_WIDTH-1:0]          sent_cnt_o,
  output logic                          busy_o
);

  localparam int AW = NURN_CNT_BIT_WIDTH + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;
  localparam logic [1:0] SEND = 2'd3;

  localparam logic [NURN_CNT_BIT_WIDTH-1:0] ID_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [1:0]               state_q;
  logic [AW-1:0]            addr_q;
  logic [3:0]               rem_q;
  logic                     mc_q;
  logic                     chain_q;
  logic                     pkt_valid_q;
  logic [AER_BIT_WIDTH-1:0] pkt_data_q;
  logic [CNT_WIDTH-1:0]     cnt_q;

  logic accept;
  logic hshake;
  logic more;
  logic no_pkts;

  assign accept  = (state_q == IDLE) & spike_valid_i;
  assign no_pkts = multicast_i & (spike_aer_num_i == 4'd0);
  assign hshake  = (state_q == SEND) & pkt_valid_q & pkt_ready_i;
  assign more    = mc_q & chain_q & (rem_q != 4'd0);

  assign spike_ready_o = (state_q == IDLE) & ~rst_i;
  assign aer_rd_en_o   = (state_q == READ);
  assign aer_addr_o    = addr_q;
  assign pkt_valid_o   = pkt_valid_q;
  assign pkt_data_o    = pkt_data_q;
  assign sent_cnt_o    = cnt_q;
  assign busy_o        = (state_q != IDLE);

  // Sequencing: one event at a time, read/load/send per entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept && !no_pkts) state_q <= READ;
        READ: state_q <= LOAD;
        LOAD: state_q <= SEND;
        SEND: if (hshake) state_q <= more ? READ : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Event latch, entry capture, packet handshake and sent counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      rem_q       <= '0;
      mc_q        <= 1'b0;
      chain_q     <= 1'b0;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        mc_q <= multicast_i;
        if (multicast_i) begin
          addr_q <= {1'b1, spike_aer_ptr_i};
          rem_q  <= spike_aer_num_i;
        end else begin
          addr_q <= {1'b0, spike_nurn_id_i};
          rem_q  <= 4'd1;
        end
      end
      if (state_q == LOAD) begin
        pkt_data_q  <= {1'b0, aer_data_i[AER_BIT_WIDTH-2:0]};
        chain_q     <= aer_data_i[AER_BIT_WIDTH-1];
        rem_q       <= rem_q - 4'd1;
        pkt_valid_q <= 1'b1;
      end
      if (hshake) begin
        pkt_valid_q <= 1'b0;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_ONE;
        if (more) addr_q[AW-2:0] <= addr_q[AW-2:0] + ID_ONE;
      end
    end
  end

endmodule
